// File: rtl/audio_volume_ramp.sv
// audio_volume_ramp: master volume stage for 24-bit stereo samples.
// A 16-bit unsigned Q1.15 gain ramps toward its target once per frame.
// One shared signed multiplier scales L and then R. Results are
// saturated to 24 bits, and sticky clip and overrun flags are kept.
module audio_volume_ramp #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 16,
  parameter logic [COEF_W-1:0] RAMP_STEP = 16'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              vol_wr,
  input  logic [7:0]        vol_lsb,
  input  logic [7:0]        vol_msb,
  input  logic              mute,
  input  logic              clip_clr,
  input  logic              l_data_en,
  input  logic              r_data_en,
  input  logic [DATA_W-1:0] l_data_in,
  input  logic [DATA_W-1:0] r_data_in,
  output logic              l_data_valid,
  output logic              r_data_valid,
  output logic [DATA_W-1:0] l_data_out,
  output logic [DATA_W-1:0] r_data_out,
  output logic [COEF_W-1:0] gain_current,
  output logic              clip_l,
  output logic              clip_r,
  output logic              overrun
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int FRAC_W = COEF_W - 1;
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, OUT} state_t;

  state_t                    state, state_next;
  logic                      accept, overrun_set;
  logic [COEF_W-1:0]         target, gain_use, eff_target;
  logic signed [DATA_W-1:0]  l_cap_p0, r_cap_p0;
  logic signed [DATA_W-1:0]  mul_a;
  logic signed [COEF_W:0]    mul_b;
  logic signed [PROD_W-1:0]  product, scaled;
  logic signed [DATA_W-1:0]  l_hold_p1;
  logic                      clip_l_p1;
  logic                      vld_p2;
  logic                      out_stage, clip_l_set, clip_r_set;

  // The shifted product overflows when its bits above the 24-bit sign
  // position are not all copies of the sign.
  function automatic logic overflows(input logic signed [PROD_W-1:0] s);
    logic [PROD_W-DATA_W:0] top;
    top = s[PROD_W-1:DATA_W-1];
    return !((&top) || (~|top));
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PROD_W-1:0] s);
    if (overflows(s)) return s[PROD_W-1] ? SAT_MIN : SAT_MAX;
    return $signed(s[DATA_W-1:0]);
  endfunction

  // Move one step toward the target without overshooting it.
  function automatic logic [COEF_W-1:0] ramp(input logic [COEF_W-1:0] cur,
                                             input logic [COEF_W-1:0] tgt);
    if (cur < tgt) return ((tgt - cur) > RAMP_STEP) ? cur + RAMP_STEP : tgt;
    if (cur > tgt) return ((cur - tgt) > RAMP_STEP) ? cur - RAMP_STEP : tgt;
    return tgt;
  endfunction

  // A same-cycle volume write takes part in this frame's ramp step.
  assign eff_target = mute   ? '0 :
                      vol_wr ? {vol_msb, vol_lsb} : target;

  // Next state, frame acceptance, and overrun detection.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    overrun_set = run && r_data_en && (state != IDLE);
    if (!run) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (r_data_en) begin
          state_next = MUL_L;
          accept     = 1'b1;
        end
        MUL_L:   state_next = MUL_R;
        MUL_R:   state_next = OUT;
        OUT:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // p0: input capture runs on every strobe, even while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_cap_p0 <= '0;
      r_cap_p0 <= '0;
    end else begin
      if (l_data_en) l_cap_p0 <= l_data_in;
      if (r_data_en) r_cap_p0 <= r_data_in;
    end
  end

  // The target register resets to unity, so the stage fades in after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       target <= 16'h8000;
    else if (vol_wr) target <= {vol_msb, vol_lsb};
  end

  // The frame latches the pre-ramp gain, then gain_current takes one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gain_current <= '0;
      gain_use     <= '0;
    end else if (!run) begin
      gain_current <= '0;
    end else if (accept) begin
      gain_use     <= gain_current;
      gain_current <= ramp(gain_current, eff_target);
    end
  end

  // Shared multiplier: L in MUL_L and R in MUL_R. The arithmetic shift
  // truncates toward minus infinity.
  assign mul_a   = (state == MUL_L) ? l_cap_p0 : r_cap_p0;
  assign mul_b   = $signed({1'b0, gain_use});
  assign product = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign scaled  = product >>> FRAC_W;

  // p1: the saturated L result waits while R is multiplied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_hold_p1 <= '0;
      clip_l_p1 <= 1'b0;
    end else if (state == MUL_L) begin
      l_hold_p1 <= saturate(scaled);
      clip_l_p1 <= overflows(scaled);
    end
  end

  assign out_stage  = run && (state == MUL_R);
  assign clip_l_set = out_stage && clip_l_p1;
  assign clip_r_set = out_stage && overflows(scaled);

  // p2: L and R are presented together with a one-cycle valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_data_out <= '0;
      r_data_out <= '0;
      vld_p2     <= 1'b0;
    end else begin
      vld_p2 <= out_stage;
      if (out_stage) begin
        l_data_out <= l_hold_p1;
        r_data_out <= saturate(scaled);
      end
    end
  end

  assign l_data_valid = vld_p2;
  assign r_data_valid = vld_p2;

  // Sticky flags. A set event in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_l  <= 1'b0;
      clip_r  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clip_l_set)       clip_l <= 1'b1;
      else if (clip_clr)    clip_l <= 1'b0;
      if (clip_r_set)       clip_r <= 1'b1;
      else if (clip_clr)    clip_r <= 1'b0;
      if (overrun_set)      overrun <= 1'b1;
      else if (clip_clr)    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_volume_ramp.sv
// Testbench for audio_volume_ramp. A reference model of gain ramping,
// scaling and saturation is checked against directed and random frames.
module tb_audio_volume_ramp;

  logic        clk, reset, run, vol_wr, mute, clip_clr;
  logic [7:0]  vol_lsb, vol_msb;
  logic        l_data_en, r_data_en;
  logic [23:0] l_data_in, r_data_in, l_data_out, r_data_out;
  logic        l_data_valid, r_data_valid;
  logic [15:0] gain_current;
  logic        clip_l, clip_r, overrun;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int          g_m, t_m;
  bit          clipl_m, clipr_m, ovr_m;
  logic [23:0] lo_m, ro_m;

  audio_volume_ramp dut (
    .clk(clk), .reset(reset), .run(run), .vol_wr(vol_wr),
    .vol_lsb(vol_lsb), .vol_msb(vol_msb), .mute(mute), .clip_clr(clip_clr),
    .l_data_en(l_data_en), .r_data_en(r_data_en),
    .l_data_in(l_data_in), .r_data_in(r_data_in),
    .l_data_valid(l_data_valid), .r_data_valid(r_data_valid),
    .l_data_out(l_data_out), .r_data_out(r_data_out),
    .gain_current(gain_current), .clip_l(clip_l), .clip_r(clip_r),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Gain moves toward the target by at most 64 per frame.
  function automatic int ramp_to(input int g, input int tgt);
    if (tgt > g + 64) return g + 64;
    if (tgt < g - 64) return g - 64;
    return tgt;
  endfunction

  // x * g / 2^15, rounded toward minus infinity, clamped to 24-bit signed.
  function automatic logic [23:0] scale(input int x, input int g, output bit clip);
    longint p, q;
    p = longint'(x) * longint'(g);
    q = p / 32768;
    if ((p % 32768) != 0 && p < 0) q = q - 1;
    clip = 1'b0;
    if (q > 8388607) begin
      q = 8388607;
      clip = 1'b1;
    end else if (q < -8388608) begin
      q = -8388608;
      clip = 1'b1;
    end
    return q[23:0];
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 16777215)) - 8388608;
  endfunction

  task automatic model_reset();
    g_m = 0; t_m = 32768;
    clipl_m = 0; clipr_m = 0; ovr_m = 0;
    lo_m = '0; ro_m = '0;
  endtask

  task automatic write_vol(input int v);
    vol_wr = 1'b1;
    {vol_msb, vol_lsb} = 16'(v);
    tick();
    vol_wr = 1'b0;
    t_m = v;
  endtask

  task automatic pulse_clr();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    clipl_m = 0; clipr_m = 0; ovr_m = 0;
  endtask

  // One full frame. The volume write is optional and shares the strobe cycle.
  task automatic frame(input int l, input int r, input bit wr, input int wv);
    bit cl, cr;
    logic [23:0] el, er;
    el = scale(l, g_m, cl);
    er = scale(r, g_m, cr);
    if (wr) t_m = wv;
    g_m = ramp_to(g_m, mute ? 0 : t_m);
    l_data_in = 24'(l); r_data_in = 24'(r);
    l_data_en = 1'b1; r_data_en = 1'b1;
    vol_wr = wr; {vol_msb, vol_lsb} = 16'(wv);
    tick();
    l_data_en = 1'b0; r_data_en = 1'b0; vol_wr = 1'b0;
    check("gain_step", 32'(gain_current), 32'(g_m));
    tick();
    tick();
    clipl_m |= cl; clipr_m |= cr;
    lo_m = el; ro_m = er;
    check("l_valid", 32'(l_data_valid), 32'd1);
    check("r_valid", 32'(r_data_valid), 32'd1);
    check("l_out", 32'(l_data_out), 32'(el));
    check("r_out", 32'(r_data_out), 32'(er));
    check("clip_l", 32'(clip_l), 32'(clipl_m));
    check("clip_r", 32'(clip_r), 32'(clipr_m));
    check("overrun", 32'(overrun), 32'(ovr_m));
    tick();
    check("valid_one_cycle", 32'(l_data_valid), 32'd0);
  endtask

  initial begin
    bit cl, cr;
    logic [23:0] el, er, neg;
    int d;
    reset = 1'b1; run = 1'b0; vol_wr = 1'b0; mute = 1'b0; clip_clr = 1'b0;
    vol_lsb = '0; vol_msb = '0; l_data_en = 1'b0; r_data_en = 1'b0;
    l_data_in = '0; r_data_in = '0;
    model_reset();
    tick();
    tick();
    check("rst_l_out", 32'(l_data_out), 32'd0);
    check("rst_r_out", 32'(r_data_out), 32'd0);
    check("rst_valid", 32'({l_data_valid, r_data_valid}), 32'd0);
    check("rst_gain", 32'(gain_current), 32'd0);
    check("rst_flags", 32'({clip_l, clip_r, overrun}), 32'd0);
    reset = 1'b0;
    run = 1'b1;
    tick();

    // fade in to unity
    for (int i = 0; i < 600; i++) frame(32'h123456, -32'sh123456, 1'b0, 0);
    neg = 24'(-32'sh123456);
    check("unity_gain", 32'(gain_current), 32'h8000);
    check("unity_l", 32'(l_data_out), 32'h123456);
    check("unity_r", 32'(r_data_out), 32'(neg));

    // ramp up to the maximum gain with random data
    write_vol(16'hFFFF);
    for (int i = 0; i < 512; i++) frame(rand_sample(), rand_sample(), 1'b0, 0);
    check("max_gain", 32'(gain_current), 32'hFFFF);
    pulse_clr();
    check("clr_flags", 32'({clip_l, clip_r}), 32'd0);
    frame(32'h400000, 0, 1'b0, 0);
    check("x2_l", 32'(l_data_out), 32'h7FFF80);
    check("x2_noclip", 32'(clip_l), 32'd0);
    frame(32'h7FFFFF, 0, 1'b0, 0);
    check("sat_pos", 32'(l_data_out), 32'h7FFFFF);
    check("sat_pos_flag", 32'(clip_l), 32'd1);
    frame(0, -32'sh800000, 1'b0, 0);
    check("sat_neg", 32'(r_data_out), 32'h800000);
    check("sat_neg_flag", 32'(clip_r), 32'd1);
    pulse_clr();
    check("clr_both", 32'({clip_l, clip_r}), 32'd0);

    // second strobe two cycles after the first
    el = scale(32'h010000, g_m, cl);
    er = scale(-32'sh020000, g_m, cr);
    g_m = ramp_to(g_m, t_m);
    l_data_in = 24'h010000; r_data_in = 24'(-32'sh020000);
    l_data_en = 1'b1; r_data_en = 1'b1;
    tick();
    l_data_en = 1'b0; r_data_en = 1'b0;
    check("ovr_valid_t1", 32'(l_data_valid), 32'd0);
    tick();
    l_data_in = 24'h333333; r_data_in = 24'h444444;
    l_data_en = 1'b1; r_data_en = 1'b1;
    tick();
    l_data_en = 1'b0; r_data_en = 1'b0;
    ovr_m = 1; lo_m = el; ro_m = er;
    check("ovr_valid", 32'(r_data_valid), 32'd1);
    check("ovr_l", 32'(l_data_out), 32'(el));
    check("ovr_r", 32'(r_data_out), 32'(er));
    check("ovr_flag", 32'(overrun), 32'd1);
    tick();
    check("ovr_single", 32'(l_data_valid), 32'd0);
    tick();
    check("ovr_no_second", 32'(l_data_valid), 32'd0);
    check("ovr_gain", 32'(gain_current), 32'(g_m));
    pulse_clr();
    check("ovr_clr", 32'(overrun), 32'd0);
    frame(32'h7FFFFF, -32'sh800000, 1'b0, 0);

    // asynchronous reset in the middle of a frame
    l_data_in = 24'h100000; r_data_in = 24'h100000;
    l_data_en = 1'b1; r_data_en = 1'b1;
    tick();
    l_data_en = 1'b0; r_data_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_l_out", 32'(l_data_out), 32'd0);
    check("arst_r_out", 32'(r_data_out), 32'd0);
    check("arst_gain", 32'(gain_current), 32'd0);
    check("arst_flags", 32'({clip_l, clip_r, overrun}), 32'd0);
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    check("arst_no_valid", 32'(l_data_valid), 32'd0);
    tick();
    check("arst_no_valid2", 32'(r_data_valid), 32'd0);

    // drop run while a frame is in flight
    for (int i = 0; i < 20; i++) frame(rand_sample(), rand_sample(), 1'b0, 0);
    g_m = ramp_to(g_m, t_m);
    l_data_in = 24'h055555; r_data_in = 24'h066666;
    l_data_en = 1'b1; r_data_en = 1'b1;
    tick();
    l_data_en = 1'b0; r_data_en = 1'b0;
    check("drop_gain_t1", 32'(gain_current), 32'(g_m));
    tick();
    run = 1'b0;
    tick();
    g_m = 0;
    check("drop_no_valid", 32'(l_data_valid), 32'd0);
    check("drop_gain0", 32'(gain_current), 32'd0);
    check("drop_hold_l", 32'(l_data_out), 32'(lo_m));
    tick();
    check("drop_no_valid2", 32'(r_data_valid), 32'd0);
    run = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) frame(rand_sample(), rand_sample(), 1'b0, 0);
    check("refade_unity", 32'(gain_current), 32'h8000);

    // a small target step must not overshoot
    write_vol(16'h8010);
    frame(rand_sample(), rand_sample(), 1'b0, 0);
    check("no_overshoot", 32'(gain_current), 32'h8010);

    // mute fades to zero
    mute = 1'b1;
    for (int i = 0; i < 514; i++) frame(rand_sample(), rand_sample(), 1'b0, 0);
    check("mute_gain", 32'(gain_current), 32'd0);
    check("mute_l", 32'(l_data_out), 32'd0);
    check("mute_r", 32'(r_data_out), 32'd0);
    mute = 1'b0;

    // random volume, mute and data
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) write_vol(int'($urandom_range(0, 65535)));
      mute = ($urandom_range(0, 4) == 0);
      frame(rand_sample(), rand_sample(), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 65535)));
      d = int'($urandom_range(0, 2));
      for (int k = 0; k < d; k++) tick();
      if ($urandom_range(0, 9) == 0) pulse_clr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_volume_ramp.md
# audio_volume_ramp

Master volume stage directly downstream of the equalizer gain/accumulate stage. It takes the equalizer's 24-bit stereo samples and frame strobes and applies a CPU-programmed 16-bit master gain. The gain is ramped sample-by-sample to avoid zipper noise. The result is saturated to 24 bits and passed to the output formatter with the same strobe convention.

## Interface
- RAMP_STEP, 16'd64: gain change per frame while current gain ≠ effective target.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  stage enable; low forces idle and zero gain.
- vol_wr  in  1  one-cycle strobe; loads target gain from {vol_msb, vol_lsb}.
- vol_lsb, vol_msb  in  8 each  target gain bytes, unsigned Q1.15 (0x8000 = unity, 0xFFFF ≈ 2.0).
- mute  in  1  level; forces effective target to 0 (ramped, not instant).
- clip_clr  in  1  one-cycle strobe; clears sticky clip flags.
- l_data_en, r_data_en  in  1 each  one-cycle input strobes; r_data_en is the frame strobe.
- l_data_in, r_data_in  in  24 each  signed input samples.
- l_data_valid, r_data_valid  out  1 each  one-cycle output strobes.
- l_data_out, r_data_out  out  24 each  signed scaled samples.
- gain_current  out  16  gain currently applied.
- clip_l, clip_r  out  1 each  sticky saturation flags.
- overrun  out  1  sticky; a frame strobe arrived while busy. Cleared by clip_clr.

## Operation
- Reset values: outputs 0, valids 0, flags 0, gain_current 0, target 0x8000. The stage fades in to unity after reset.
- Capture: the L sample is registered on l_data_en and the R sample on r_data_en. The strobes may coincide, or L may precede R.
- Effective target is 0 if mute is high; otherwise it is the target register.
- FSM states: IDLE, MUL_L, MUL_R, OUT.
  - IDLE → MUL_L on r_data_en while run is high. The gain is sampled into gain_use at the same time.
  - MUL_L → MUL_R → OUT → IDLE unconditionally.
- The multiplier is a single shared signed 24 × 17 unit, with the gain zero-extended to 17 bits. L is multiplied in MUL_L and R in MUL_R, giving 41-bit products.
- Scaling: result = product >>> 15, an arithmetic shift that truncates toward −inf.
- Saturation: results above 0x7FFFFF clamp to 0x7FFFFF; results below −0x800000 clamp to 0x800000. A clamp sets the matching clip flag.
- Ramp: in the cycle after an accepted frame strobe, gain_current moves toward the effective target by RAMP_STEP. It is clamped so it never overshoots. Each frame therefore uses the gain from before its own ramp update.
- Clip and overrun flags: if clip_clr and a new set event occur in the same cycle, set wins.
- vol_wr in the same cycle as a frame strobe: the target updates, and that frame's ramp step uses the new target.
- Frame strobe while the FSM is not IDLE: the strobe is ignored and overrun is set. Input capture registers still update.
- run low (sampled each cycle):
  - FSM returns to IDLE and any in-flight frame is dropped with no valid pulse.
  - gain_current is forced to 0 and outputs hold their last values.
  - Target is retained.
- reset mid-frame: all state returns to reset values immediately (asynchronous).

## Timing
- Frame strobe at cycle T (FSM in IDLE, run high):
  - MUL_L at T+1.
  - MUL_R at T+2, with L saturated into a holding register.
  - OUT at T+3: l_data_out and r_data_out update together, and l_data_valid and r_data_valid are high for exactly cycle T+3.
- Latency is 3 cycles from r_data_en to valid. Minimum strobe spacing is 4 cycles; a strobe at T+1..T+3 counts as an overrun.
- gain_current updates at T+1. Clip flags assert at T+3.
- vol_wr takes effect on the target register the next cycle.

## Test plan
- Reset → all outputs 0, gain_current 0. Run high, mute low, 600 frames of 0x123456 / −0x123456:
  - gain_current rises by 64 per frame and reaches 0x8000 after frame 512.
  - After that, outputs equal the inputs exactly.
- Target 0xFFFF reached:
  - L = 0x400000 → 0x7FFF80, no clip.
  - L = 0x7FFFFF → 0x7FFFFF with clip_l set.
  - R = 0x800000 → 0x800000 with clip_r set.
  - clip_clr → both flags clear.
- gain_current 0x8000, write target 0x8010 → next frame ramps to exactly 0x8010 (no overshoot). Mute high → gain_current falls by 64 per frame to 0 and outputs become 0.
- Strobe at T, again at T+2 → one valid pulse at T+3 with the first frame's data, overrun = 1.
- run dropped at T+2 after a strobe at T → no valid pulse, gain_current = 0. Re-raise run → fade in from 0.
- Assert reset at T+1 mid-frame → no valid pulse; all outputs and flags return to 0 asynchronously.
